// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single core memory port between instruction fetch (IF) and the
// data-cache request stream (DC). One transaction is in flight at a time;
// when both requesters are pending the one not served last wins.
//
// Each transaction walks IDLE -> REQ -> WAIT -> IDLE. The request fields are
// captured on acceptance and drive the bus unchanged until granted. The
// response is registered and pulsed on the owning requester's rvalid. The
// cycle after a response is a turnaround in which no new request is accepted.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   if_req_valid_i        fetch request, held until if_ready_o
//   if_addr_i             fetch address (word aligned)
//   if_ready_o            fetch request accepted this cycle
//   if_rvalid_o/if_rdata_o  fetched instruction, 1-cycle pulse
//   dc_req_valid_i        data request, held until dc_ready_o
//   dc_wen_i/dc_addr_i/dc_wdata_i/dc_wlen_i/dc_sext_i  data request fields
//   dc_ready_o            data request accepted this cycle
//   dc_rvalid_o/dc_rdata_o  load data (aligned, extended) or store ack (0)
//   stall_o               data access pending or outstanding
//   mem_req_o/mem_wen_o/mem_addr_o/mem_wdata_o/mem_wstrb_o  bus request
//   mem_gnt_i             bus accepted the request
//   mem_rvalid_i/mem_rdata_i  bus read data / write ack
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64   // fixed at 64: eight byte lanes
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              dc_req_valid_i,
  input  logic              dc_wen_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  input  logic [1:0]        dc_wlen_i,
  input  logic              dc_sext_i,
  output logic              dc_ready_o,
  output logic              dc_rvalid_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [7:0]        mem_wstrb_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {SRC_IF = 1'b0, SRC_DC = 1'b1} src_t;

  state_t state, state_nxt;
  src_t   last_grant, src_q;
  logic   turn_q;           // high in the turnaround cycle after a response
  logic   grant_if, grant_dc, accept, resp;

  logic              wen_q, sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        wlen_q;
  logic [2:0]        off;
  logic [7:0]        strb_base;
  logic [DATA_W-1:0] load_shifted, load_fmt;

  assign off    = addr_q[2:0];
  assign accept = grant_if | grant_dc;
  assign resp   = (state == S_WAIT) && mem_rvalid_i;

  assign if_ready_o = grant_if;
  assign dc_ready_o = grant_dc;
  assign stall_o    = (dc_req_valid_i & ~grant_dc) |
                      ((src_q == SRC_DC) && (state != S_IDLE));

  // Arbitration, next state and bus outputs.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt   = state;
    grant_if    = 1'b0;
    grant_dc    = 1'b0;
    mem_req_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    case (state)
      S_IDLE: begin
        if (!turn_q) begin
          if (if_req_valid_i && dc_req_valid_i) begin
            // Round-robin: the side that did not win last time goes first.
            if (last_grant == SRC_IF) grant_dc = 1'b1;
            else                      grant_if = 1'b1;
          end else begin
            grant_if = if_req_valid_i;
            grant_dc = dc_req_valid_i;
          end
          if (if_req_valid_i || dc_req_valid_i) state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_o  = 1'b1;
        mem_wen_o  = wen_q;
        mem_addr_o = {addr_q[ADDR_W-1:3], 3'b000};
        if (wen_q) begin
          mem_wdata_o = wdata_q << {off, 3'b000};
          // Shifting in an 8-bit context drops strobes past the top lane.
          mem_wstrb_o = strb_base << off;
        end
        if (mem_gnt_i) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (wlen_q)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // Load alignment: move the addressed byte to lane 0, then extend.
  always_comb begin
    load_shifted = mem_rdata_i >> {off, 3'b000};
    case (wlen_q)
      2'd0:    load_fmt = {{(DATA_W-8){sext_q & load_shifted[7]}},   load_shifted[7:0]};
      2'd1:    load_fmt = {{(DATA_W-16){sext_q & load_shifted[15]}}, load_shifted[15:0]};
      2'd2:    load_fmt = {{(DATA_W-32){sext_q & load_shifted[31]}}, load_shifted[31:0]};
      default: load_fmt = load_shifted;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Capture registers and registered responses.
  // NOTE: the datapath registers are reset as well: the bus and response
  // outputs are driven from them and must read 0 out of reset, and a reset
  // mid-transaction must leave nothing behind that could look like a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant  <= SRC_IF;
      src_q       <= SRC_IF;
      turn_q      <= 1'b0;
      wen_q       <= 1'b0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wlen_q      <= 2'd0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      dc_rvalid_o <= 1'b0;
      dc_rdata_o  <= '0;
    end else begin
      turn_q      <= resp;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      dc_rvalid_o <= 1'b0;
      dc_rdata_o  <= '0;
      if (accept) begin
        src_q      <= grant_dc ? SRC_DC : SRC_IF;
        last_grant <= grant_dc ? SRC_DC : SRC_IF;
        if (grant_dc) begin
          wen_q   <= dc_wen_i;
          addr_q  <= dc_addr_i;
          wdata_q <= dc_wdata_i;
          wlen_q  <= dc_wlen_i;
          sext_q  <= dc_sext_i;
        end else begin
          wen_q   <= 1'b0;
          addr_q  <= if_addr_i;
          wdata_q <= '0;
          wlen_q  <= 2'd2;
          sext_q  <= 1'b0;
        end
      end
      if (resp) begin
        if (src_q == SRC_DC) begin
          dc_rvalid_o <= 1'b1;
          dc_rdata_o  <= wen_q ? '0 : load_fmt;
        end else begin
          if_rvalid_o <= 1'b1;
          if_rdata_o  <= addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. The bench plays both requesters
// and the memory. Directed vectors come from a table of hand-computed
// records; random transactions are checked against arithmetic reference
// functions. Hand-written sequences cover round-robin under continuous
// contention, a slow grant, and reset during an outstanding access.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid_i;
  logic [63:0] if_addr_i;
  logic        if_ready_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dc_req_valid_i, dc_wen_i, dc_sext_i;
  logic [63:0] dc_addr_i, dc_wdata_i;
  logic [1:0]  dc_wlen_i;
  logic        dc_ready_o, dc_rvalid_o;
  logic [63:0] dc_rdata_o;
  logic        stall_o, mem_req_o, mem_wen_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid_i(if_req_valid_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_wen_i(dc_wen_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_wlen_i(dc_wlen_i), .dc_sext_i(dc_sext_i),
    .dc_ready_o(dc_ready_o), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
    .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_if_rv = 0;
  int n_dc_rv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if_rvalid_o === 1'b1) n_if_rv <= n_if_rv + 1;
    if (dc_rvalid_o === 1'b1) n_dc_rv <= n_dc_rv + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [7:0] m_strb(input logic [2:0] off, input logic [1:0] wlen);
    int bytes, base, sh;
    bytes = 1 << wlen;
    base  = (1 << bytes) - 1;
    sh    = base << off;
    return sh[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wdata, input logic [2:0] off);
    return wdata << (8 * off);
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [2:0] off,
                                         input logic [1:0] wlen, input bit sext);
    logic [63:0] s, mask;
    int nb;
    s  = rdata >> (8 * off);
    nb = 8 << wlen;
    if (nb < 64) begin
      mask = (64'd1 << nb) - 64'd1;
      s = s & mask;
      if (sext && s[nb-1]) s = s | ~mask;
    end
    return s;
  endfunction

  function automatic logic [63:0] m_fetch(input logic [63:0] rdata, input logic [63:0] addr);
    logic [63:0] s;
    s = rdata >> (addr[2] ? 32 : 0);
    return {32'd0, s[31:0]};
  endfunction

  // ---------------- one complete transaction ----------------
  task automatic txn(input bit is_dc, input bit wen, input bit sext,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] rdata, input logic [1:0] wlen,
                     input logic [7:0] e_strb, input logic [63:0] e_wdata,
                     input logic [63:0] e_rdata, input int gnt_dly, input int rv_dly,
                     input bit hold_if, input string tag);
    bit got;
    int acc_cyc;
    @(negedge clk);
    if (is_dc) begin
      dc_req_valid_i = 1'b1; dc_wen_i = wen; dc_addr_i = addr;
      dc_wdata_i = wdata; dc_wlen_i = wlen; dc_sext_i = sext;
    end else begin
      if_req_valid_i = 1'b1; if_addr_i = addr;
    end
    got = 1'b0;
    acc_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (is_dc ? dc_ready_o : if_ready_o) begin
        got = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check({tag, ".accept"}, got, 1);
    if (!got) begin
      dc_req_valid_i = 1'b0;
      if_req_valid_i = 1'b0;
      return;
    end
    check({tag, ".other_ready"}, is_dc ? if_ready_o : dc_ready_o, 0);
    // request phase
    @(negedge clk);
    dc_req_valid_i = 1'b0;
    if_req_valid_i = 1'b0;
    if (hold_if) begin
      if_req_valid_i = 1'b1;
      if_addr_i = 64'h9000;
    end
    #1;
    check({tag, ".mem_req"}, mem_req_o, 1);
    check({tag, ".mem_addr"}, mem_addr_o, addr & ~64'h7);
    check({tag, ".mem_wen"}, mem_wen_o, is_dc & wen);
    check({tag, ".mem_wstrb"}, mem_wstrb_o, e_strb);
    if (is_dc && wen) check({tag, ".mem_wdata"}, mem_wdata_o, e_wdata);
    if (is_dc) check({tag, ".stall_req"}, stall_o, 1);
    for (int g = 0; g < gnt_dly; g++) begin
      @(negedge clk); #1;
      check({tag, ".req_hold"}, mem_req_o, 1);
      check({tag, ".addr_hold"}, mem_addr_o, addr & ~64'h7);
      check({tag, ".no_accept"}, {if_ready_o, dc_ready_o}, 0);
    end
    mem_gnt_i = 1'b1;
    // wait phase
    @(negedge clk);
    mem_gnt_i = 1'b0;
    if_req_valid_i = 1'b0;
    #1;
    check({tag, ".req_drop"}, mem_req_o, 0);
    for (int r = 0; r < rv_dly; r++) begin
      @(negedge clk); #1;
      check({tag, ".early_rv"}, {if_rvalid_o, dc_rvalid_o}, 0);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    // response cycle
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = {$urandom, $urandom};
    #1;
    if (is_dc) begin
      check({tag, ".dc_rvalid"}, dc_rvalid_o, 1);
      check({tag, ".dc_rdata"}, dc_rdata_o, e_rdata);
      check({tag, ".if_quiet"}, if_rvalid_o, 0);
    end else begin
      check({tag, ".if_rvalid"}, if_rvalid_o, 1);
      check({tag, ".if_rdata"}, {32'd0, if_rdata_o}, e_rdata);
      check({tag, ".dc_quiet"}, dc_rvalid_o, 0);
    end
    check({tag, ".stall_done"}, stall_o, 0);
    check({tag, ".latency"}, cyc - acc_cyc, 3 + gnt_dly + rv_dly);
    @(negedge clk); #1;
    check({tag, ".pulse"}, {if_rvalid_o, dc_rvalid_o}, 0);
  endtask

  typedef struct {
    string       name;
    bit          is_dc;
    bit          wen;
    bit          sext;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  wlen;
    logic [63:0] rdata;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vq[$];

  initial begin
    int ng, nd0, ni0;
    bit gp;
    bit src_log[4];
    int acc_c[4];

    // expected values computed by hand
    vq.push_back('{"ld_b_sx",  1, 0, 1, 64'h1003, 64'h0, 2'd0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80});
    vq.push_back('{"st_h",     1, 1, 0, 64'h2006, 64'h1234, 2'd1, 64'h0, 8'hC0, 64'h1234_0000_0000_0000, 64'h0});
    vq.push_back('{"if_hi",    0, 0, 0, 64'h8000_0004, 64'h0, 2'd2, 64'h0000_0013_DEAD_BEEF, 8'h00, 64'h0, 64'h0000_0013});
    vq.push_back('{"if_lo",    0, 0, 0, 64'h8000_0000, 64'h0, 2'd2, 64'h0000_0013_DEAD_BEEF, 8'h00, 64'h0, 64'hDEAD_BEEF});
    vq.push_back('{"ld_w_zx",  1, 0, 0, 64'h3004, 64'h0, 2'd2, 64'h8765_4321_0000_0000, 8'h00, 64'h0, 64'h0000_0000_8765_4321});
    vq.push_back('{"ld_w_sx",  1, 0, 1, 64'h3004, 64'h0, 2'd2, 64'h8765_4321_0000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321});
    vq.push_back('{"ld_h_pos", 1, 0, 1, 64'h0010, 64'h0, 2'd1, 64'h0000_0000_0000_7FFF, 8'h00, 64'h0, 64'h0000_0000_0000_7FFF});
    vq.push_back('{"ld_h_neg", 1, 0, 1, 64'h2002, 64'h0, 2'd1, 64'h0000_0000_8001_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001});
    vq.push_back('{"ld_b_zx",  1, 0, 0, 64'h1003, 64'h0, 2'd0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_0080});
    vq.push_back('{"ld_d",     1, 0, 1, 64'h0048, 64'h0, 2'd3, 64'hCAFE_F00D_1234_5678, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678});
    vq.push_back('{"st_b_top", 1, 1, 0, 64'h0107, 64'hAB, 2'd0, 64'h0, 8'h80, 64'hAB00_0000_0000_0000, 64'h0});
    vq.push_back('{"st_d",     1, 1, 0, 64'h0200, 64'h0123_4567_89AB_CDEF, 2'd3, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0});
    vq.push_back('{"st_w_hi",  1, 1, 0, 64'h0304, 64'hDEAD_BEEF, 2'd2, 64'h0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0});
    vq.push_back('{"st_w_mis", 1, 1, 0, 64'h0306, 64'h1122_3344, 2'd2, 64'h0, 8'hC0, 64'h3344_0000_0000_0000, 64'h0});

    // reset state
    rst = 1'b0;
    if_req_valid_i = 0; if_addr_i = '0;
    dc_req_valid_i = 0; dc_wen_i = 0; dc_addr_i = '0; dc_wdata_i = '0;
    dc_wlen_i = '0; dc_sext_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.mem_req", mem_req_o, 0);
    check("rst.mem_wen", mem_wen_o, 0);
    check("rst.mem_addr", mem_addr_o, 0);
    check("rst.mem_wdata", mem_wdata_o, 0);
    check("rst.mem_wstrb", mem_wstrb_o, 0);
    check("rst.rvalids", {if_rvalid_o, dc_rvalid_o}, 0);
    check("rst.readys", {if_ready_o, dc_ready_o}, 0);
    check("rst.if_rdata", if_rdata_o, 0);
    check("rst.dc_rdata", dc_rdata_o, 0);
    check("rst.stall", stall_o, 0);
    rst = 1'b1;

    // table-driven vectors
    foreach (vq[i])
      txn(vq[i].is_dc, vq[i].wen, vq[i].sext, vq[i].addr, vq[i].wdata, vq[i].rdata,
          vq[i].wlen, vq[i].e_strb, vq[i].e_wdata, vq[i].e_rdata, 0, 0, 0, vq[i].name);

    // slow grant with a competing fetch held valid throughout
    txn(1, 0, 1, 64'h5004, 64'h0, 64'hFFEE_DDCC_BBAA_9988, 2'd1, 8'h00, 64'h0,
        64'hFFFF_FFFF_FFFF_DDCC, 5, 2, 1, "slow_gnt");

    // randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      bit is_dc, wen, sext;
      logic [1:0] wlen;
      logic [63:0] addr, wdata, rdata, mask, e_rd, e_wd;
      logic [7:0] e_st;
      is_dc = 1'($urandom);
      wen   = is_dc & 1'($urandom);
      sext  = 1'($urandom);
      wlen  = 2'($urandom);
      addr  = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      mask  = (wlen == 2'd3) ? '1 : ((64'd1 << (8 << wlen)) - 64'd1);
      wdata = {$urandom, $urandom} & mask;
      if (!is_dc) addr[1:0] = 2'b00;
      e_st = (is_dc && wen) ? m_strb(addr[2:0], wlen) : 8'h00;
      e_wd = m_wdata(wdata, addr[2:0]);
      if (!is_dc)   e_rd = m_fetch(rdata, addr);
      else if (wen) e_rd = 64'h0;
      else          e_rd = m_load(rdata, addr[2:0], wlen, sext);
      txn(is_dc, wen, sext, addr, wdata, rdata, wlen, e_st, e_wd, e_rd,
          $urandom_range(0, 3), $urandom_range(0, 3), 0, $sformatf("rnd%0d", n));
    end

    // round-robin: both requesters valid from reset and held
    @(negedge clk);
    rst = 1'b0;
    if_req_valid_i = 1'b1; if_addr_i = 64'h100;
    dc_req_valid_i = 1'b1; dc_wen_i = 1'b0; dc_addr_i = 64'h200;
    dc_wlen_i = 2'd3; dc_sext_i = 1'b0;
    mem_rdata_i = 64'h1111_2222_3333_4444;
    @(negedge clk);
    rst = 1'b1;
    nd0 = n_dc_rv; ni0 = n_if_rv;
    ng = 0; gp = 1'b0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      check("rr.exclusive", if_ready_o & dc_ready_o, 0);
      if (dc_ready_o || if_ready_o) begin
        src_log[ng] = dc_ready_o;
        acc_c[ng] = cyc;
        ng++;
      end
      mem_rvalid_i = gp;
      mem_gnt_i = mem_req_o;
      gp = mem_gnt_i;
      @(negedge clk);
    end
    if_req_valid_i = 1'b0;
    dc_req_valid_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      mem_rvalid_i = gp;
      mem_gnt_i = mem_req_o;
      gp = mem_gnt_i;
      @(negedge clk);
    end
    mem_rvalid_i = 1'b0;
    mem_gnt_i = 1'b0;
    check("rr.count", ng, 4);
    if (ng == 4) begin
      check("rr.g0_dc", src_log[0], 1);
      check("rr.g1_if", src_log[1], 0);
      check("rr.g2_dc", src_log[2], 1);
      check("rr.g3_if", src_log[3], 0);
      for (int i = 1; i < 4; i++)
        check($sformatf("rr.spacing%0d", i), (acc_c[i] - acc_c[i-1]) >= 4, 1);
    end
    check("rr.dc_resps", n_dc_rv - nd0, 2);
    check("rr.if_resps", n_if_rv - ni0, 2);

    // reset while waiting for the response, late rvalid afterwards
    @(negedge clk);
    dc_req_valid_i = 1'b1; dc_wen_i = 1'b0; dc_addr_i = 64'h40;
    dc_wlen_i = 2'd3; dc_sext_i = 1'b0;
    #1;
    check("rstw.accept", dc_ready_o, 1);
    @(negedge clk);
    dc_req_valid_i = 1'b0;
    #1;
    check("rstw.mem_req", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    #1;
    check("rstw.in_wait", mem_req_o, 0);
    check("rstw.stall_out", stall_o, 1);
    rst = 1'b0;
    #1;
    check("rstw.stall_clr", stall_o, 0);
    @(negedge clk);
    rst = 1'b1;
    nd0 = n_dc_rv; ni0 = n_if_rv;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    check("rstw.idle_req", mem_req_o, 0);
    repeat (3) @(negedge clk);
    check("rstw.no_resp", (n_dc_rv - nd0) + (n_if_rv - ni0), 0);
    txn(1, 0, 0, 64'h0041, 64'h0, 64'h0000_0000_0000_FE00, 2'd0, 8'h00, 64'h0,
        64'h0000_0000_0000_00FE, 0, 0, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between instruction fetch (IF) and the data-cache request stream issued by the decode stage (valid/wen/wdata/addr/wlen).
- Accepts one transaction at a time and arbitrates round-robin when both requesters are pending.
- Drives a request/grant/response memory bus, generates byte strobes and store-data lane placement, and aligns and extends load data.
- Raises a pipeline stall while a data access is outstanding.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory bus data width (fixed 64; byte lanes = DATA_W/8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_valid_i  in  1  fetch request; held until accepted.
- if_addr_i  in  ADDR_W  fetch address (word aligned).
- if_ready_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch response, 1-cycle pulse.
- if_rdata_o  out  32  fetched instruction.
- dc_req_valid_i  in  1  data request; held until accepted.
- dc_wen_i  in  1  1 = store, 0 = load.
- dc_addr_i  in  ADDR_W  byte address.
- dc_wdata_i  in  64  store data, right-justified.
- dc_wlen_i  in  2  size: 0 = byte, 1 = half, 2 = word, 3 = double.
- dc_sext_i  in  1  sign-extend load result.
- dc_ready_o  out  1  data request accepted this cycle.
- dc_rvalid_o  out  1  data response or store ack, 1-cycle pulse.
- dc_rdata_o  out  64  aligned, extended load data (0 for stores).
- stall_o  out  1  data access pending or outstanding.
- mem_req_o  out  1  bus request.
- mem_wen_o  out  1  bus write.
- mem_addr_o  out  ADDR_W  doubleword-aligned address (addr[2:0] forced to 0).
- mem_wdata_o  out  64  lane-shifted store data.
- mem_wstrb_o  out  8  byte strobes.
- mem_gnt_i  in  1  bus accepted request.
- mem_rvalid_i  in  1  read data valid / write ack.
- mem_rdata_i  in  64  doubleword read data.

Behaviour:

Reset values:
- All outputs 0; state IDLE; last_grant = IF.

State machine:
- IDLE: ready asserted combinationally to at most one requester.
  - Only one requester valid → grant it.
  - Both valid → grant the one not equal to last_grant.
  - On valid & ready: capture source, wen, addr, wdata, wlen, sext; update last_grant; go to REQ next cycle.
- REQ: mem_req_o = 1; all mem_* outputs driven from captured registers and held stable. On mem_gnt_i → WAIT.
- WAIT: mem_req_o = 0. On mem_rvalid_i:
  - Pulse the rvalid of the captured source for 1 cycle, with data registered in the same cycle.
  - Go to IDLE.
  - mem_rvalid_i in IDLE or REQ is ignored.
- Minimum latency from acceptance to rvalid is 3 cycles with zero-wait gnt/rvalid. There is a mandatory 1-cycle IDLE turnaround, so back-to-back accepts are 1 per 4 cycles minimum.

Store formatting (off = addr[2:0]):
- mem_wdata_o = dc_wdata << (8·off).
- mem_wstrb_o = base << off, where base is 0x01 / 0x03 / 0x0F / 0xFF for wlen 0 / 1 / 2 / 3.
- Truncate to 8 bits. Misalignment is not checked; decode already traps it.
- Loads and fetches: mem_wstrb_o = 0, mem_wen_o = 0.

Load formatting:
- s = mem_rdata_i >> (8·off).
- Keep the low 8/16/32/64 bits per wlen.
- If sext, sign-extend from the top kept bit; otherwise zero-extend.
- Fetch: if_rdata_o = addr[2] ? rdata[63:32] : rdata[31:0].
- Store ack: dc_rdata_o = 0.

stall_o:
- = (dc_req_valid_i & ~dc_ready_o) | (captured source = DC & state ≠ IDLE).
- Deasserts in the cycle dc_rvalid_o pulses.

Reset:
- Reset asserted mid-transaction abandons it immediately: no rvalid is issued and state returns to IDLE.
- A late mem_rvalid_i after reset release is ignored because state is IDLE.

Requester rules:
- Request fields may change only after ready.
- Dropping valid before ready is allowed; the request is then never issued.

Test Plan:
1. Reset, then single load: dc addr 0x1003, wlen 0, sext 1, gnt and rvalid immediate, rdata 0x00000000_80000000 → mem_addr_o 0x1000, dc_rvalid_o 3 cycles after accept, dc_rdata_o 0xFFFF_FFFF_FFFF_FF80; stall_o high from request until that cycle.
2. Store half at addr 0x2006, wdata 0x1234 → mem_wstrb_o 0xC0, mem_wdata_o 0x1234_0000_0000_0000, mem_wen_o 1; dc_rvalid_o on ack with dc_rdata_o 0.
3. Fetch at 0x8000_0004, rdata 0x00000013_DEADBEEF → if_rdata_o 0x00000013, dc_* outputs quiet.
4. Both valid from reset, held continuously → grants in order DC, IF, DC, IF; accepts no closer than 4 cycles apart.
5. mem_gnt_i delayed 5 cycles → mem_req_o and mem_addr_o stable throughout; no second accept occurs.
6. rst asserted while in WAIT, then mem_rvalid_i pulses after release → no rvalid output; next request is served normally.
